bus_mem_slave: RTL and testbench
================================

// Module: bus_mem_slave
// PURPOSE
//  Bus responder: the memory end of the shared system bus whose initiators are the I/D caches.
//  Decodes a 32-bit byte address against a base window and serves word reads/writes from an
//  internal RAM after a programmable number of wait states.
//  Handshake: one BUS_ready pulse per transfer. Drives BUS_data/BUS_ready only when addressed,
//  so several slaves may share the bus.
// PARAMETERS
//  ADDR_W   10        word-address width; RAM depth = 2**ADDR_W 32-bit words
//  BASE     32'h0     byte base of window; selected when addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]
//  WAIT     2         wait cycles inserted before BUS_ready (0..255)
// PORTS
//  clk        in     1   system clock, all state on posedge
//  clr        in     1   reset, synchronous, active-high
//  BUS_addr   in     32  byte address from granted master; bits [1:0] ignored
//  BUS_data   inout  32  write data in; read data driven only in ACK of a read, else 'z'
//  BUS_req    in     1   transfer valid from granted master; addr/data/RW stable while high
//  BUS_RW     in     1   1 = write, 0 = read
//  BUS_ready  out    1   tri-state: 0 in WAIT, 1 in ACK, 'z' in IDLE/RECOVER and when not selected
// BEHAVIOUR
//  sel = BUS_req & window match; idx = BUS_addr[ADDR_W+1:2].
//  States: IDLE, WAIT, ACK, RECOVER. Wait counter cnt is 8 bits.
//  Reset (clr sampled high): state=IDLE, cnt=0, rdata=0; BUS_ready='z', BUS_data='z'.
//   RAM contents are not cleared. clr overrides everything, including mid-transfer.
//   An aborted write never commits.
//  IDLE: sel -> WAIT with cnt=WAIT-1 if WAIT>0, else straight to ACK (commit as below).
//   Otherwise stay in IDLE.
//  WAIT: BUS_ready driven 0. If BUS_req falls -> IDLE, no RAM access (abort).
//   cnt!=0 -> cnt-1. cnt==0 -> ACK.
//  Entering ACK (same edge): write -> mem[idx] <= BUS_data. Read -> rdata <= mem[idx].
//  ACK: exactly 1 cycle. BUS_ready driven 1. Read: BUS_data = rdata. Write: BUS_data = 'z'.
//   Next state is RECOVER unconditionally.
//  RECOVER: 1 cycle, outputs 'z', BUS_req ignored. Lets master drop req and arbiter re-grant.
//   Then -> IDLE.
//  Latency: req accepted at edge k -> BUS_ready high during cycle k+1+WAIT.
//   Minimum spacing between accepts is WAIT+3 cycles.
//  Master rule: sample BUS_ready at posedge. Read data is valid on that same edge.
//   Deassert or change req after it.
//  A req still high in IDLE after RECOVER is a new transfer (back-to-back allowed).
//  Out-of-window address: never leaves IDLE, never drives the bus. Leaves RAM untouched.
//  Address change while in WAIT is a master protocol error. The slave uses addr/data as
//   sampled at the ACK-entry edge.
//  Write/read of the same word back-to-back: the read returns the new data (no bypass needed,
//   given the RECOVER gap).
// TESTING
//  1 Reset: clr=1 for 2 cycles with req=1 -> BUS_ready and BUS_data stay 'z'; state IDLE after release.
//  2 Read, WAIT=2: preload mem[1]=32'hab2112b; req=1, RW=0, addr=4 at edge k
//     -> ready 0 in cycles k+1..k+2, 1 in k+3 with data 32'hab2112b, 'z' at k+4.
//  3 Write then read: write 32'hab21123 to addr 20; release; read addr 20 -> returns 32'hab21123.
//    Then write addr 24 and read addr 20 -> still 32'hab21123.
//  4 Abort: write 32'hdeadbeef to addr 16; drop req in the 2nd WAIT cycle
//     -> no ready pulse; later read of addr 16 returns the old value.
//  5 Decode, BASE=32'h1000: req to addr 32'h0004 -> bus stays 'z' for 10 cycles.
//    Req to addr 32'h1004 -> served from mem[1].
//  6 WAIT=0 with req held high across 3 reads -> ready pulses at edges k+1, k+4, k+7.
//    Clr asserted in a WAIT cycle -> IDLE next cycle, no commit.

Source files
------------

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: the memory end of the shared system bus.
// It decodes a 32-bit byte address against a base window. It serves 32-bit word reads
// and writes from an internal RAM after WAIT wait states.
// BUS_ready and BUS_data are released to 'z' whenever this slave is not addressed, so
// several slaves can share the same bus wires.
module bus_mem_slave #(
   parameter int unsigned ADDR_W = 10,
   parameter logic [31:0] BASE   = 32'h0,
   parameter int unsigned WAIT   = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] BUS_addr,
   inout  wire  [31:0] BUS_data,
   input  logic        BUS_req,
   input  logic        BUS_RW,
   output wire         BUS_ready
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Value loaded into the wait counter on accept: the number of WAIT cycles minus one.
   localparam logic [7:0] WAIT_INIT = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_RECOVER
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q;
   logic        rw_q;

   logic [31:0] mem [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic              win_hit;
   logic              sel;
   logic              commit;

   logic              ready_oe;
   logic              ready_val;
   logic              data_oe;

   // Byte-lane bits carry no information for word transfers.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^BUS_addr[1:0];

   assign idx     = BUS_addr[ADDR_W+1:2];
   assign win_hit = (BUS_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
   assign sel     = BUS_req & win_hit;

   // The RAM access happens on the edge that moves the FSM into ACK.
   // With zero wait states, that edge is the accept edge out of IDLE.
   // Otherwise it is the edge that ends the last WAIT cycle while req is still held.
   // A reset on that same edge cancels the access, so an aborted write never lands.
   assign commit = ~clr & (
                      ((state_q == ST_IDLE) & sel & (WAIT == 0)) |
                      ((state_q == ST_WAIT) & BUS_req & (cnt_q == 8'd0))
                   );

   // State register: FSM state, wait counter, read-data holding register and transfer direction.
   always_ff @(posedge clk) begin
      // NOTE: every register update uses <= so that all flops sample pre-edge values together.
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         rdata_q <= 32'd0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            rw_q <= BUS_RW;
            if (!BUS_RW) begin
               rdata_q <= mem[idx];
            end
         end
      end
   end

   // RAM write port: capture the bus data on the ACK-entry edge of a write.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array has no reset; its contents survive clr and only the control state is cleared.
      if (commit && BUS_RW) begin
         mem[idx] <= BUS_data;
      end
   end

   // Next-state logic: accept, count wait states, abort on req drop, then ACK and RECOVER for one cycle each.
   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sel) begin
               if (WAIT == 0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!BUS_req) begin
               state_d = ST_IDLE;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: drive ready low while waiting and high in ACK; drive read data only in a read ACK.
   always_comb begin
      ready_oe  = 1'b0;
      ready_val = 1'b0;
      data_oe   = 1'b0;
      unique case (state_q)
         ST_WAIT: begin
            ready_oe  = 1'b1;
            ready_val = 1'b0;
         end
         ST_ACK: begin
            ready_oe  = 1'b1;
            ready_val = 1'b1;
            data_oe   = ~rw_q;
         end
         default: begin
            ready_oe  = 1'b0;
            ready_val = 1'b0;
            data_oe   = 1'b0;
         end
      endcase
   end

   assign BUS_ready = ready_oe ? ready_val : 1'bz;
   assign BUS_data  = data_oe  ? rdata_q   : 32'bz;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave. It builds three instances on separate bus segments:
//   u_a : BASE 0, WAIT 2; ready and data pulled up, so 'z' reads as all ones.
//   u_b : BASE 32'h1000, WAIT 2; ready and data pulled up.
//   u_c : BASE 0, WAIT 0; ready pulled down, so only an ACK reads as 1; data pulled up.
module tb_bus_mem_slave;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] addr;
   logic        rw;
   logic [31:0] wdata;
   logic        req_a, req_b, req_c;
   logic        oe_a, oe_b, oe_c;

   tri1 [31:0]  data_a, data_b, data_c;
   tri1         ready_a, ready_b;
   tri0         ready_c;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   assign data_a = oe_a ? wdata : 32'bz;
   assign data_b = oe_b ? wdata : 32'bz;
   assign data_c = oe_c ? wdata : 32'bz;

   bus_mem_slave #(.ADDR_W(10), .BASE(32'h0), .WAIT(2)) u_a (
      .clk(clk), .clr(clr), .BUS_addr(addr), .BUS_data(data_a),
      .BUS_req(req_a), .BUS_RW(rw), .BUS_ready(ready_a)
   );

   bus_mem_slave #(.ADDR_W(10), .BASE(32'h1000), .WAIT(2)) u_b (
      .clk(clk), .clr(clr), .BUS_addr(addr), .BUS_data(data_b),
      .BUS_req(req_b), .BUS_RW(rw), .BUS_ready(ready_b)
   );

   bus_mem_slave #(.ADDR_W(10), .BASE(32'h0), .WAIT(0)) u_c (
      .clk(clk), .clr(clr), .BUS_addr(addr), .BUS_data(data_c),
      .BUS_req(req_c), .BUS_RW(rw), .BUS_ready(ready_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int u);
      return (u == 0) ? ready_a : ready_b;
   endfunction

   function automatic logic [31:0] dat(input int u);
      return (u == 0) ? data_a : data_b;
   endfunction

   // One full transfer on a WAIT=2 instance (u=0 -> u_a, u=1 -> u_b).
   // It checks the ready sequence 0,0,1 and returns the bus data seen in the ACK cycle.
   task automatic xfer(input int u, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input string tag, output logic [31:0] rdv);
      addr  = a;
      rw    = wr;
      wdata = wd;
      if (u == 0) begin req_a = 1'b1; oe_a = wr; end
      else        begin req_b = 1'b1; oe_b = wr; end
      step();
      check({tag, " wait1 ready"}, 32'(rdy(u)), 32'd0);
      step();
      check({tag, " wait2 ready"}, 32'(rdy(u)), 32'd0);
      step();
      check({tag, " ack ready"}, 32'(rdy(u)), 32'd1);
      rdv = dat(u);
      step();
      req_a = 1'b0; req_b = 1'b0; oe_a = 1'b0; oe_b = 1'b0;
      #1;
      if (!wr) check({tag, " recover data z"}, dat(u), 32'hffff_ffff);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr   = 1'b1;
      addr  = 32'd4;
      rw    = 1'b0;
      wdata = 32'd0;
      req_a = 1'b1; req_b = 1'b0; req_c = 1'b1;
      oe_a  = 1'b0; oe_b  = 1'b0; oe_c  = 1'b0;

      // 1. Reset held for two cycles with req high: nothing is driven.
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst ready_a z", 32'(ready_a), 32'd1);
         check("rst data_a z", data_a, 32'hffff_ffff);
         check("rst ready_c no ack", 32'(ready_c), 32'd0);
         check("rst data_c z", data_c, 32'hffff_ffff);
      end
      req_a = 1'b0; req_c = 1'b0; clr = 1'b0;
      step();
      check("post rst ready_a idle", 32'(ready_a), 32'd1);
      check("post rst ready_c idle", 32'(ready_c), 32'd0);

      // 2. Preload mem[1], then read addr 4 with the full WAIT=2 timing.
      xfer(0, 1'b1, 32'd4, 32'h0ab2112b, "t2 wr4", rd);
      xfer(0, 1'b0, 32'd4, 32'h0, "t2 rd4", rd);
      check("t2 rd4 data", rd, 32'h0ab2112b);

      // 3. Write then read, then write a neighbouring word and re-read.
      xfer(0, 1'b1, 32'd20, 32'h0ab21123, "t3 wr20", rd);
      xfer(0, 1'b0, 32'd20, 32'h0, "t3 rd20", rd);
      check("t3 rd20 data", rd, 32'h0ab21123);
      xfer(0, 1'b1, 32'd24, 32'h1234_5678, "t3 wr24", rd);
      xfer(0, 1'b0, 32'd20, 32'h0, "t3 rd20b", rd);
      check("t3 rd20 after wr24", rd, 32'h0ab21123);
      xfer(0, 1'b0, 32'd24, 32'h0, "t3 rd24", rd);
      check("t3 rd24 data", rd, 32'h1234_5678);

      // 4. Abort: req drops in the second WAIT cycle; the write must not commit.
      xfer(0, 1'b1, 32'd16, 32'h1111_0000, "t4 wr16 old", rd);
      addr = 32'd16; rw = 1'b1; wdata = 32'hdead_beef; oe_a = 1'b1; req_a = 1'b1;
      step();
      check("t4 abort wait1", 32'(ready_a), 32'd0);
      step();
      check("t4 abort wait2", 32'(ready_a), 32'd0);
      req_a = 1'b0; oe_a = 1'b0;
      step();
      check("t4 abort idle", 32'(ready_a), 32'd1);
      step();
      xfer(0, 1'b0, 32'd16, 32'h0, "t4 rd16", rd);
      check("t4 rd16 old value", rd, 32'h1111_0000);

      // 5. Decode with BASE 32'h1000: in-window write, then out-of-window read and write.
      xfer(1, 1'b1, 32'h1004, 32'hcafe_f00d, "t5 wr1004", rd);
      addr = 32'h0004; rw = 1'b0; req_b = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5 oow ready z", 32'(ready_b), 32'd1);
         check("t5 oow data z", data_b, 32'hffff_ffff);
      end
      rw = 1'b1; wdata = 32'hbadb_ad00; oe_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5 oow wr ready z", 32'(ready_b), 32'd1);
      end
      req_b = 1'b0; oe_b = 1'b0;
      step();
      xfer(1, 1'b0, 32'h1004, 32'h0, "t5 rd1004", rd);
      check("t5 rd1004 data", rd, 32'hcafe_f00d);

      // 6a. WAIT=0 with req held across three reads: ACK at steps 1, 4 and 7.
      addr = 32'd8; rw = 1'b1; wdata = 32'h5a5a_0001; oe_c = 1'b1; req_c = 1'b1;
      step();
      check("t6 c wr ack", 32'(ready_c), 32'd1);
      step();
      req_c = 1'b0; oe_c = 1'b0;
      step();
      rw = 1'b0; req_c = 1'b1;
      for (int s = 1; s <= 10; s++) begin
         step();
         check($sformatf("t6 c ready step %0d", s), 32'(ready_c),
               (s == 1 || s == 4 || s == 7) ? 32'd1 : 32'd0);
         if (s == 1 || s == 4 || s == 7) check($sformatf("t6 c data step %0d", s), data_c, 32'h5a5a_0001);
         if (s == 8) req_c = 1'b0;
      end

      // 6b. clr in a WAIT cycle: back to IDLE next cycle, and the write does not commit.
      addr = 32'd16; rw = 1'b1; wdata = 32'h7777_7777; oe_a = 1'b1; req_a = 1'b1;
      step();
      check("t6 clr pre wait", 32'(ready_a), 32'd0);
      clr = 1'b1;
      step();
      check("t6 clr idle", 32'(ready_a), 32'd1);
      clr = 1'b0; req_a = 1'b0; oe_a = 1'b0;
      step();
      check("t6 clr stays idle", 32'(ready_a), 32'd1);
      xfer(0, 1'b0, 32'd16, 32'h0, "t6 rd16", rd);
      check("t6 rd16 no commit", rd, 32'h1111_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
